// File: rtl/adf4159_load_sched.sv
// adf4159_load_sched
// Turns the TX/RX frequency triggers into per-channel load requests for the
// ADF4159 synthesizers. Each channel runs its own load/busy handshake, keeps
// at most one queued load, and flags a missing busy acknowledge.
// Optional feature macro: ADF4159_LOAD_STAGGER_EN. When it is defined, at most
// one channel starts a load per cycle, chosen round-robin.
module adf4159_load_sched #(
  parameter int CH_NUM         = 6,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              trig_tx,
  input  logic              trig_rx,
  input  logic [CH_NUM-1:0] tx_mask,
  input  logic [CH_NUM-1:0] rx_mask,
  input  logic [CH_NUM-1:0] busy,
  input  logic              err_clr,
  output logic [CH_NUM-1:0] load,
  output logic [CH_NUM-1:0] pending,
  output logic [CH_NUM-1:0] active,
  output logic [CH_NUM-1:0] timeout_err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  // Last counter value before an unacknowledged load is abandoned.
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  // Trigger synchronizers plus one history flop each.
  logic tx_s1_q, tx_s1_d, tx_s2_q, tx_s2_d, tx_hist_q, tx_hist_d;
  logic rx_s1_q, rx_s1_d, rx_s2_q, rx_s2_d, rx_hist_q, rx_hist_d;
  logic tx_edge_s, rx_edge_s;
  logic [CH_NUM-1:0] req_s;

  // Per-channel state.
  state_t      state_q [CH_NUM];
  state_t      state_d [CH_NUM];
  logic [15:0] cnt_q   [CH_NUM];
  logic [15:0] cnt_d   [CH_NUM];

  logic [CH_NUM-1:0] load_q, load_d;
  logic [CH_NUM-1:0] pending_q, pending_d;
  logic [CH_NUM-1:0] active_q, active_d;
  logic [CH_NUM-1:0] err_q, err_d;

  // Channels allowed to enter ACK this cycle, and those given the go-ahead.
  logic [CH_NUM-1:0] ready_s;
  logic [CH_NUM-1:0] grant_s;

  // Shift triggers through the synchronizer and derive the request set.
  always_comb begin
    tx_s1_d   = trig_tx;
    tx_s2_d   = tx_s1_q;
    tx_hist_d = tx_s2_q;
    rx_s1_d   = trig_rx;
    rx_s2_d   = rx_s1_q;
    rx_hist_d = rx_s2_q;
    tx_edge_s = tx_s2_q & ~tx_hist_q;
    rx_edge_s = rx_s2_q & ~rx_hist_q;
    req_s     = ({CH_NUM{tx_edge_s}} & tx_mask) | ({CH_NUM{rx_edge_s}} & rx_mask);
  end

  // A channel is ready to start a load when it has work and busy is low.
  always_comb begin
    ready_s = {CH_NUM{1'b0}};
    for (int i = 0; i < CH_NUM; i++) begin
      case (state_q[i])
        ST_IDLE: ready_s[i] = pending_q[i] & ~busy[i];
        ST_WAIT: ready_s[i] = ~busy[i];
        default: ready_s[i] = 1'b0;
      endcase
    end
  end

`ifdef ADF4159_LOAD_STAGGER_EN
  localparam int PTR_W = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(CH_NUM - 1);

  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;

  // Grant the first ready channel at or after the pointer; pointer moves past it.
  always_comb begin
    logic             found;
    logic [PTR_W-1:0] idx;
    grant_s  = {CH_NUM{1'b0}};
    rr_ptr_d = rr_ptr_q;
    found    = 1'b0;
    idx      = {PTR_W{1'b0}};
    for (int k = 0; k < CH_NUM; k++) begin
      idx = PTR_W'((int'(rr_ptr_q) + k) % CH_NUM);
      if (!found && ready_s[idx]) begin
        found        = 1'b1;
        grant_s[idx] = 1'b1;
        rr_ptr_d     = (idx == PTR_LAST) ? {PTR_W{1'b0}} : (idx + PTR_W'(1));
      end else begin
        found = found;
      end
    end
  end

  // Round-robin pointer register; starts at channel 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr_q <= {PTR_W{1'b0}};
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end
`else
  // Every ready channel starts its load in the same cycle.
  always_comb begin
    grant_s = ready_s;
  end
`endif

  // Per-channel handshake FSM next state plus pending/error/active updates.
  always_comb begin
    logic [CH_NUM-1:0] start_v;
    logic [CH_NUM-1:0] tmo_v;
    start_v = {CH_NUM{1'b0}};
    tmo_v   = {CH_NUM{1'b0}};
    load_d  = load_q;
    for (int i = 0; i < CH_NUM; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        ST_IDLE: begin
          if (pending_q[i] && grant_s[i]) begin
            state_d[i] = ST_ACK;
            load_d[i]  = 1'b1;
            cnt_d[i]   = 16'd0;
            start_v[i] = 1'b1;
          end else if (pending_q[i] && busy[i]) begin
            state_d[i] = ST_WAIT;
            load_d[i]  = 1'b0;
          end else begin
            state_d[i] = ST_IDLE;
            load_d[i]  = 1'b0;
          end
        end
        ST_WAIT: begin
          if (grant_s[i]) begin
            state_d[i] = ST_ACK;
            load_d[i]  = 1'b1;
            cnt_d[i]   = 16'd0;
            start_v[i] = 1'b1;
          end else begin
            state_d[i] = ST_WAIT;
            load_d[i]  = 1'b0;
          end
        end
        ST_ACK: begin
          if (busy[i]) begin
            state_d[i] = ST_IDLE;
            load_d[i]  = 1'b0;
          end else if (cnt_q[i] == TMO_LAST) begin
            state_d[i] = ST_IDLE;
            load_d[i]  = 1'b0;
            tmo_v[i]   = 1'b1;
          end else begin
            state_d[i] = ST_ACK;
            load_d[i]  = 1'b1;
            cnt_d[i]   = cnt_q[i] + 16'd1;
          end
        end
        default: begin
          state_d[i] = ST_IDLE;
          load_d[i]  = 1'b0;
          cnt_d[i]   = 16'd0;
        end
      endcase
    end

    // A request in the start cycle re-arms pending for one more load.
    pending_d = (pending_q & ~start_v) | req_s;

    // A timeout in the same cycle as err_clr still leaves the flag set.
    if (err_clr) begin
      err_d = tmo_v;
    end else begin
      err_d = err_q | tmo_v;
    end

    for (int i = 0; i < CH_NUM; i++) begin
      active_d[i] = (state_d[i] == ST_WAIT) || (state_d[i] == ST_ACK);
    end
  end

  // Register synchronizers, channel FSMs and all outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_s1_q   <= 1'b1;
      tx_s2_q   <= 1'b1;
      tx_hist_q <= 1'b1;
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_hist_q <= 1'b1;
      load_q    <= {CH_NUM{1'b0}};
      pending_q <= {CH_NUM{1'b0}};
      active_q  <= {CH_NUM{1'b0}};
      err_q     <= {CH_NUM{1'b0}};
      for (int i = 0; i < CH_NUM; i++) begin
        state_q[i] <= ST_IDLE;
        cnt_q[i]   <= 16'd0;
      end
    end else begin
      tx_s1_q   <= tx_s1_d;
      tx_s2_q   <= tx_s2_d;
      tx_hist_q <= tx_hist_d;
      rx_s1_q   <= rx_s1_d;
      rx_s2_q   <= rx_s2_d;
      rx_hist_q <= rx_hist_d;
      load_q    <= load_d;
      pending_q <= pending_d;
      active_q  <= active_d;
      err_q     <= err_d;
      for (int i = 0; i < CH_NUM; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  assign load        = load_q;
  assign pending     = pending_q;
  assign active      = active_q;
  assign timeout_err = err_q;

endmodule
